// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [2:0] {
        StBoot,
        StFetch,
        StWait,
        StSkid,
        StDrain
    } state_t;

    typedef enum logic [1:0] {
        SelSeq,
        SelJump,
        SelBranch
    } pc_sel_t;

endpackage

// File: rtl/fetch_pc_sel.sv
// Priority next-PC selector: branch over jump over sequential, targets word aligned.
module fetch_pc_sel
    import fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        redirect,
    output logic [31:0] next_pc
);

    pc_sel_t sel;

    always_comb begin
        if (branch_taken) begin
            sel = SelBranch;
        end else if (jump) begin
            sel = SelJump;
        end else begin
            sel = SelSeq;
        end

        case (sel)
            SelBranch: next_pc = {branch_target[31:2], 2'b00};
            SelJump:   next_pc = {jump_target[31:2], 2'b00};
            default:   next_pc = pc + 32'd4;
        endcase

        redirect = (sel != SelSeq);
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, handshakes with imem, stalls, skids and flushes.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP      = NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hazard,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc4,
    output logic        flush
);

    state_t      state;
    logic [31:0] pc;
    logic [31:0] addr_hold;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc4;
    logic [31:0] next_pc;
    logic        redirect_sel;
    logic        redirect;

    fetch_pc_sel u_pc_sel (
        .pc            (pc),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .redirect      (redirect_sel),
        .next_pc       (next_pc)
    );

    // Redirects are ignored while still booting.
    assign redirect = redirect_sel && (state != StBoot);
    assign flush    = redirect;

    always_comb begin
        imem_req  = 1'b0;
        imem_addr = pc;
        case (state)
            StFetch: imem_req = !hazard;
            StWait, StDrain: begin
                imem_req  = 1'b1;
                imem_addr = addr_hold;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= StBoot;
            pc         <= RESET_PC;
            addr_hold  <= RESET_PC;
            skid_instr <= NOP;
            skid_pc4   <= 32'h0;
            if_valid   <= 1'b0;
            if_instr   <= NOP;
            if_pc4     <= 32'h0;
        end else if (redirect) begin
            pc       <= next_pc;
            if_valid <= 1'b0;
            if_instr <= NOP;
            case (state)
                StFetch: begin
                    // An unanswered request must be drained at its original address.
                    addr_hold <= pc;
                    state     <= (!hazard && !imem_ready) ? StDrain : StFetch;
                end
                StWait, StDrain: state <= imem_ready ? StFetch : StDrain;
                default:         state <= StFetch;
            endcase
        end else begin
            // Without a redirect next_pc is pc + 4.
            case (state)
                StBoot: state <= StFetch;
                StFetch: begin
                    if (!hazard) begin
                        if (imem_ready) begin
                            if_valid <= 1'b1;
                            if_instr <= imem_rdata;
                            if_pc4   <= next_pc;
                            pc       <= next_pc;
                        end else begin
                            addr_hold <= pc;
                            state     <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (imem_ready) begin
                        pc <= next_pc;
                        if (hazard) begin
                            skid_instr <= imem_rdata;
                            skid_pc4   <= next_pc;
                            state      <= StSkid;
                        end else begin
                            if_valid <= 1'b1;
                            if_instr <= imem_rdata;
                            if_pc4   <= next_pc;
                            state    <= StFetch;
                        end
                    end
                end
                StSkid: begin
                    if (!hazard) begin
                        if_valid <= 1'b1;
                        if_instr <= skid_instr;
                        if_pc4   <= skid_pc4;
                        state    <= StFetch;
                    end
                end
                StDrain: begin
                    if (imem_ready) begin
                        state <= StFetch;
                    end
                end
                default: state <= StBoot;
            endcase
        end
    end

endmodule
